// File: rtl/ldr_hit_detector.sv
// Laser target front end: synchronizes, debounces and edge-detects the LDR channels, then reports one hit per shot with a hold-off.
// Optional miss reporting is enabled by defining LDR_MISS_REPORT_EN.
module ldr_hit_detector #(
    parameter int N_SENSORS       = 7,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int HOLDOFF_CYCLES  = 5000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_SENSORS-1:0] ldr_sensors,
    input  logic                 arm,
    input  logic [2:0]           target_sel,
    input  logic                 hit_ack,
    output logic                 hit_valid,
    output logic [2:0]           hit_id,
    output logic                 hit_on_target,
    output logic [N_SENSORS-1:0] lit
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int HW = $clog2(HOLDOFF_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        REPORT  = 2'd2,
        HOLDOFF = 2'd3
    } state_t;

    state_t                state, state_nx;
    logic [N_SENSORS-1:0]  s1, s2, lit_d, rise;
    logic [CW-1:0]         cnt [N_SENSORS];
    logic [HW-1:0]         hcnt, hcnt_nx;
    logic                  valid_nx, on_nx;
    logic [2:0]            id_nx;
    logic [7:0]            rise_ext;
    logic                  tgt_rise;

    // two-flop synchronizer, inverting so that 1 means laser present
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= ~ldr_sensors;
            s2 <= s1;
        end
    end

    // per-channel debounce: level follows s2 only after a full stable run
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lit <= '0;
            for (int i = 0; i < N_SENSORS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_SENSORS; i++) begin
                if (s2[i] == lit[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    lit[i] <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // delayed level for rising-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lit_d <= '0;
        end else begin
            lit_d <= lit;
        end
    end

    assign rise = lit & ~lit_d;

    // zero-extended so out-of-range target_sel selects a constant 0
    always_comb begin
        rise_ext                = 8'd0;
        rise_ext[N_SENSORS-1:0] = rise;
        tgt_rise                = rise_ext[target_sel];
    end

`ifdef LDR_MISS_REPORT_EN
    logic       miss_found;
    logic [2:0] miss_id;

    // lowest-indexed rising channel, used when the target did not fire
    always_comb begin
        miss_found = 1'b0;
        miss_id    = 3'd0;
        for (int i = N_SENSORS - 1; i >= 0; i--) begin
            miss_id    = rise[i] ? 3'(i) : miss_id;
            miss_found = miss_found | rise[i];
        end
    end
`endif

    // next-state and capture logic for the hit reporting FSM
    always_comb begin
        state_nx = state;
        valid_nx = hit_valid;
        id_nx    = hit_id;
        on_nx    = hit_on_target;
        hcnt_nx  = hcnt;
        case (state)
            IDLE: begin
                if (arm) begin
                    state_nx = ARMED;
                end else begin
                    state_nx = IDLE;
                end
            end
            ARMED: begin
                if (!arm) begin
                    state_nx = IDLE;
                end else if (tgt_rise) begin
                    state_nx = REPORT;
                    valid_nx = 1'b1;
                    id_nx    = target_sel;
                    on_nx    = 1'b1;
`ifdef LDR_MISS_REPORT_EN
                end else if (miss_found) begin
                    state_nx = REPORT;
                    valid_nx = 1'b1;
                    id_nx    = miss_id;
                    on_nx    = 1'b0;
`endif
                end else begin
                    state_nx = ARMED;
                end
            end
            REPORT: begin
                if (hit_ack) begin
                    state_nx = HOLDOFF;
                    valid_nx = 1'b0;
                    hcnt_nx  = HOLD_LOAD;
                end else begin
                    state_nx = REPORT;
                end
            end
            HOLDOFF: begin
                if (hcnt == '0) begin
                    state_nx = arm ? ARMED : IDLE;
                end else begin
                    hcnt_nx  = hcnt - HW'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                valid_nx = 1'b0;
            end
        endcase
    end

    // FSM state and registered event outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            hcnt          <= '0;
            hit_valid     <= 1'b0;
            hit_id        <= 3'd0;
            hit_on_target <= 1'b0;
        end else begin
            state         <= state_nx;
            hcnt          <= hcnt_nx;
            hit_valid     <= valid_nx;
            hit_id        <= id_nx;
            hit_on_target <= on_nx;
        end
    end

endmodule

// File: tb/tb_ldr_hit_detector.sv
// Randomized and directed bench for ldr_hit_detector against a run-length / event-level reference model.
// Model follows LDR_MISS_REPORT_EN the same way the design does.
module tb_ldr_hit_detector;

    localparam int N = 7;
    localparam int D = 4;
    localparam int H = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] ldr;
    logic         arm;
    logic [2:0]   target_sel;
    logic         hit_ack;
    logic         hit_valid;
    logic [2:0]   hit_id;
    logic         hit_on_target;
    logic [N-1:0] lit;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    logic [N-1:0] m_s1, m_s2, m_lit, m_litd;
    int           m_run [N];
    int           m_mode;      // 0 idle, 1 armed, 2 report, 3 holdoff
    int           m_edge = 0;
    int           m_release;
    logic         m_valid, m_on;
    logic [2:0]   m_id;

    ldr_hit_detector #(
        .N_SENSORS(N), .DEBOUNCE_CYCLES(D), .HOLDOFF_CYCLES(H)
    ) dut (
        .clk(clk), .rst(rst), .ldr_sensors(ldr), .arm(arm),
        .target_sel(target_sel), .hit_ack(hit_ack),
        .hit_valid(hit_valid), .hit_id(hit_id),
        .hit_on_target(hit_on_target), .lit(lit)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_lit = '0; m_litd = '0;
        for (int i = 0; i < N; i++) m_run[i] = 0;
        m_mode = 0; m_valid = 1'b0; m_id = 3'd0; m_on = 1'b0;
    endtask

    // predicts the state after the coming clock edge from the current inputs
    task automatic model_step();
        logic [7:0]   rise;
        logic [N-1:0] new_lit;
        m_edge++;
        if (rst) begin
            model_reset();
            return;
        end
        rise = 8'd0;
        rise[N-1:0] = m_lit & ~m_litd;
        case (m_mode)
            0: if (arm) m_mode = 1;
            1: begin
                if (!arm) begin
                    m_mode = 0;
                end else if (int'(target_sel) < N && rise[target_sel]) begin
                    m_mode = 2; m_valid = 1'b1; m_id = target_sel; m_on = 1'b1;
                end else begin
`ifdef LDR_MISS_REPORT_EN
                    for (int i = 0; i < N; i++) begin
                        if (rise[i] && m_mode == 1) begin
                            m_mode = 2; m_valid = 1'b1; m_id = 3'(i); m_on = 1'b0;
                        end
                    end
`endif
                end
            end
            2: if (hit_ack) begin
                m_mode = 3; m_valid = 1'b0; m_release = m_edge + H;
            end
            default: if (m_edge == m_release) m_mode = arm ? 1 : 0;
        endcase
        new_lit = m_lit;
        for (int i = 0; i < N; i++) begin
            if (m_s2[i] != m_lit[i]) begin
                m_run[i]++;
                if (m_run[i] == D) begin
                    new_lit[i] = m_s2[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_litd = m_lit;
        m_lit  = new_lit;
        m_s2   = m_s1;
        m_s1   = ~ldr;
    endtask

    task automatic compare_all();
        check("hit_valid", hit_valid, m_valid);
        if (m_valid) begin
            check("hit_id", hit_id, m_id);
            check("hit_on_target", hit_on_target, m_on);
        end
        check("lit", lit, m_lit);
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    // releases every laser and drains any pending event
    task automatic settle();
        ldr = '1; hit_ack = 1'b1;
        run(2);
        hit_ack = 1'b0;
        run(D + H + 6);
    endtask

    logic seen_valid, seen_lit;

    initial begin
        rst = 1'b1; ldr = '1; arm = 1'b0; target_sel = 3'd0; hit_ack = 1'b0;
        model_reset();
        run(2);
        rst = 1'b0;
        run(3);
        check("reset_valid", hit_valid, 0);
        check("reset_lit", lit, 0);

        // mid-run reset with all sensors dark
        arm = 1'b1;
        run(4);
        #2 rst = 1'b1;
        #1 model_reset();
        check("rst_valid", hit_valid, 0);
        check("rst_id", hit_id, 0);
        check("rst_on", hit_on_target, 0);
        check("rst_lit", lit, 0);
        run(1);
        rst = 1'b0;
        run(3);

        // glitch shorter than the debounce window
        target_sel = 3'd3;
        ldr[3] = 1'b0;
        run(3);
        ldr[3] = 1'b1;
        seen_valid = 1'b0; seen_lit = 1'b0;
        for (int k = 0; k < 12; k++) begin
            cyc();
            seen_valid |= hit_valid;
            seen_lit   |= lit[3];
        end
        check("glitch_lit", seen_lit, 0);
        check("glitch_valid", seen_valid, 0);

        // target hit latency and single scoring
        ldr[3] = 1'b0;
        run(6);
        check("hit_latency_pre", hit_valid, 0);
        check("hit_lit3", lit[3], 1);
        cyc();
        check("hit_valid_e7", hit_valid, 1);
        check("hit_id_e7", hit_id, 3);
        check("hit_on_e7", hit_on_target, 1);
        run(3);
        check("hit_hold", hit_valid, 1);
        hit_ack = 1'b1;
        cyc();
        hit_ack = 1'b0;
        check("hit_drop", hit_valid, 0);
        seen_valid = 1'b0;
        for (int k = 0; k < 30; k++) begin
            cyc();
            seen_valid |= hit_valid;
        end
        check("held_no_second", seen_valid, 0);
        settle();

        // simultaneous rises, target among them
        target_sel = 3'd5;
        ldr[1] = 1'b0; ldr[5] = 1'b0;
        run(7);
        check("simul_valid", hit_valid, 1);
        check("simul_id", hit_id, 5);
        check("simul_on", hit_on_target, 1);
        settle();

        // only a non-target channel rises
        ldr[1] = 1'b0;
        run(7);
`ifdef LDR_MISS_REPORT_EN
        check("miss_valid", hit_valid, 1);
        check("miss_id", hit_id, 1);
        check("miss_on", hit_on_target, 0);
`else
        check("miss_none", hit_valid, 0);
`endif
        settle();

        // rise during hold-off is lost
        target_sel = 3'd3;
        ldr[3] = 1'b0;
        run(7);
        check("hold_pre_valid", hit_valid, 1);
        hit_ack = 1'b1;
        cyc();
        hit_ack = 1'b0;
        ldr[3] = 1'b1; ldr[2] = 1'b0;
        seen_valid = 1'b0;
        for (int k = 0; k < 25; k++) begin
            cyc();
            seen_valid |= hit_valid;
        end
        check("holdoff_discard", seen_valid, 0);
        settle();

        // arm drop during REPORT, then IDLE after hold-off
        target_sel = 3'd4;
        ldr[4] = 1'b0;
        run(7);
        arm = 1'b0;
        run(3);
        check("arm_drop_keeps", hit_valid, 1);
        hit_ack = 1'b1;
        cyc();
        hit_ack = 1'b0;
        check("arm_drop_ack", hit_valid, 0);
        run(H + 2);
        ldr[0] = 1'b0;
        run(10);
        arm = 1'b1;
        seen_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cyc();
            seen_valid |= hit_valid;
        end
        check("idle_after_hold", seen_valid, 0);
        settle();

        // reset while an event is pending
        ldr[4] = 1'b0;
        run(7);
        check("rst_report_pre", hit_valid, 1);
        #3 rst = 1'b1;
        #1 model_reset();
        check("rst_report_async", hit_valid, 0);
        run(1);
        rst = 1'b0;
        run(3);
        settle();

        // randomized traffic
        arm = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 11) == 0) ldr[i] = ~ldr[i];
            end
            if ($urandom_range(0, 39) == 0) arm = ~arm;
            if ($urandom_range(0, 7) == 0) target_sel = 3'($urandom_range(0, 7));
            hit_ack = ($urandom_range(0, 2) == 0);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
